divu_seq_divider: RTL

//  Multi-cycle unsigned divider for the DIVU funct (6'b011011): one restoring step per clock.

---
 rtl/divu_seq_divider_if.sv | 26 ++
 rtl/divu_seq_divider.sv | 108 ++++++++++
 2 files changed

// File: rtl/divu_seq_divider_if.sv
// Handshake bundle between the DIVU issue logic and the sequential divider.
// valid/ready: a beat moves on a rising edge where valid and ready are both high; nothing moves otherwise.
interface divu_seq_divider_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0]   dataA;
  logic [WIDTH-1:0]   dataB;
  logic [5:0]         Signal;
  logic               in_valid;
  logic               in_ready;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] DivAns;
  logic               div_by_zero;
  logic               busy;

  modport master (
    output dataA, dataB, Signal, in_valid, out_ready,
    input  in_ready, out_valid, DivAns, div_by_zero, busy
  );

  modport slave (
    input  dataA, dataB, Signal, in_valid, out_ready,
    output in_ready, out_valid, DivAns, div_by_zero, busy
  );
endinterface

// File: rtl/divu_seq_divider.sv
// Multi-cycle unsigned divider for DIVU: one restoring step per clock.
// DivAns = {remainder, quotient}, so HiLo loads Hi = remainder and Lo = quotient.
module divu_seq_divider #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic                     clk,
  input  logic                     reset,
  divu_seq_divider_if.slave        bus,
  output logic [1:0]               stateDbg
);

  localparam logic [5:0] DIVU = 6'b011011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state, stateNext;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   den;
  logic [WIDTH-1:0]   rem;
  logic               dbz;

  logic               accept;
  logic               lastStep;
  logic [WIDTH-1:0]   shifted;
  logic [WIDTH:0]     trial;

  // Partial remainder never exceeds WIDTH-1 significant bits before a step,
  // so dropping rem's MSB in the shift loses nothing.
  assign shifted  = {rem[WIDTH-2:0], quo[WIDTH-1]};
  assign trial    = {1'b0, shifted} - {1'b0, den};
  assign lastStep = (cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        accept = bus.in_valid && (bus.Signal == DIVU);
        if (accept) begin
          stateNext = (bus.dataB == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (lastStep) begin
          stateNext = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
      quo <= '0;
      den <= '0;
      rem <= '0;
      dbz <= 1'b0;
    end else if (accept) begin
      cnt <= '0;
      den <= bus.dataB;
      dbz <= (bus.dataB == '0);
      if (bus.dataB == '0) begin
        quo <= '1;
        rem <= bus.dataA;
      end else begin
        quo <= bus.dataA;
        rem <= '0;
      end
    end else if (state == RUN) begin
      cnt <= cnt + 1'b1;
      if (!trial[WIDTH]) begin
        rem <= trial[WIDTH-1:0];
        quo <= {quo[WIDTH-2:0], 1'b1};
      end else begin
        rem <= shifted;
        quo <= {quo[WIDTH-2:0], 1'b0};
      end
    end
  end

  assign bus.in_ready    = (state == IDLE);
  assign bus.busy        = (state == RUN);
  assign bus.out_valid   = (state == DONE);
  assign bus.DivAns      = {rem, quo};
  assign bus.div_by_zero = dbz;
  assign stateDbg        = state;

endmodule
